uart_rx: RTL and testbench

Asynchronous RS-232 byte receiver for the MD5 search board: it oversamples the raw `rs232rx` pin, recovers 8N1 frames and hands each byte to the hash-loading stage as a one-cycle strobe. It sits directly upstream of the 128-bit target-hash deserializer. That stage concatenates 16 consecutive bytes into `md5in` and raises `md5valid`. Framing errors are flagged, so the loader can discard a partially collected hash.

---
 rtl/md5_io_pkg.sv | 16 +
 rtl/sync2.sv | 22 ++
 rtl/uart_rx.sv | 108 ++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_io_pkg.sv
// Shared definitions for the MD5 search board serial I/O blocks.
// Holds the UART receiver state encoding and the default bit period.
package md5_io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITIDLE
    } uart_state_t;

    // 50 MHz system clock at 115200 baud
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
// Both flops reset to 1, which matches the idle level of the serial lines.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 RS-232 byte receiver with mid-bit sampling.
// Emits one-cycle rxvalid per good byte and one-cycle rxerr per bad stop bit.
module uart_rx
    import md5_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232rx,
    output logic [7:0] rxdata,
    output logic       rxvalid,
    output logic       rxerr
);

    // The IDLE cycle that detects the falling edge already counts toward the
    // half-bit wait, so the start-bit check fires one count earlier.
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 2);
    localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);

    logic        rx_s;
    uart_state_t state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic [7:0]  rxdata_n;
    logic        rxvalid_n, rxerr_n;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rs232rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            rxdata  <= '0;
            rxvalid <= 1'b0;
            rxerr   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            rxdata  <= rxdata_n;
            rxvalid <= rxvalid_n;
            rxerr   <= rxerr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 16'd1;
        idx_n     = idx;
        shreg_n   = shreg;
        rxdata_n  = rxdata;
        rxvalid_n = 1'b0;
        rxerr_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        rxdata_n  = shreg;
                        rxvalid_n = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        rxerr_n = 1'b1;
                        state_n = WAITIDLE;
                    end
                end
            end
            WAITIDLE: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs232rx = 1'b1;
    logic [7:0] rxdata;
    logic       rxvalid;
    logic       rxerr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int viol = 0;
    bit prev_v = 0;
    bit prev_e = 0;
    int         vq[$];
    logic [7:0] dq[$];
    int         eq[$];

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .rs232rx (rs232rx),
        .rxdata  (rxdata),
        .rxvalid (rxvalid),
        .rxerr   (rxerr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorder; latency of a strobe on frame edge E is (cyc - t0 - 1) == E
    always @(negedge clk) begin
        if (rxvalid === 1'b1) begin
            vq.push_back(cyc);
            dq.push_back(rxdata);
            if (rxerr === 1'b1 || prev_v) viol++;
        end
        if (rxerr === 1'b1) begin
            eq.push_back(cyc);
            if (prev_e) viol++;
        end
        prev_v = (rxvalid === 1'b1);
        prev_e = (rxerr === 1'b1);
    end

    task automatic clear_q();
        vq.delete();
        dq.delete();
        eq.delete();
    endtask

    task automatic idle(input int n);
        rs232rx = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; bit period is p100/100 clocks, the next edge is edge 0.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int p100, input int rst_edge);
        int bi;
        t0 = cyc;
        for (int c = 0; (c * 100) / p100 < 10; c++) begin
            bi = (c * 100) / p100;
            if (bi == 0)      rs232rx = 1'b0;
            else if (bi == 9) rs232rx = stop;
            else              rs232rx = b[bi-1];
            rst = (c == rst_edge);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        rs232rx = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rxdata !== 8'h00) begin failures++; $display("FAIL reset_rxdata got=%h exp=00", rxdata); end
        checks++;
        if (rxvalid !== 1'b0) begin failures++; $display("FAIL reset_rxvalid got=%b exp=0", rxvalid); end
        checks++;
        if (rxerr !== 1'b0) begin failures++; $display("FAIL reset_rxerr got=%b exp=0", rxerr); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
    endtask

    task automatic test_single();
        clear_q();
        send_frame(8'hA5, 1'b1, 1600, -1);
        idle(20);
        checks++;
        if (vq.size() != 1) begin
            failures++; $display("FAIL single_count got=%0d exp=1", vq.size());
        end else begin
            checks++;
            if (dq[0] !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", dq[0]); end
            checks++;
            if (vq[0] - t0 - 1 != 153) begin failures++; $display("FAIL single_edge got=%0d exp=153", vq[0] - t0 - 1); end
        end
        checks++;
        if (eq.size() != 0) begin failures++; $display("FAIL single_err got=%0d exp=0", eq.size()); end
        checks++;
        if (rxdata !== 8'hA5) begin failures++; $display("FAIL single_hold got=%h exp=a5", rxdata); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        int first;
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        clear_q();
        send_frame(exp_b[0], 1'b1, 1600, -1);
        first = t0;
        send_frame(exp_b[1], 1'b1, 1600, -1);
        send_frame(exp_b[2], 1'b1, 1600, -1);
        idle(20);
        checks++;
        if (vq.size() != 3) begin
            failures++; $display("FAIL b2b_count got=%0d exp=3", vq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dq[i] !== exp_b[i]) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, dq[i], exp_b[i]); end
                checks++;
                if (vq[i] - first - 1 != 153 + 160 * i) begin
                    failures++; $display("FAIL b2b_edge%0d got=%0d exp=%0d", i, vq[i] - first - 1, 153 + 160 * i);
                end
            end
        end
    endtask

    task automatic test_glitch();
        clear_q();
        rs232rx = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        idle(30);
        checks++;
        if (vq.size() + eq.size() != 0) begin
            failures++; $display("FAIL glitch_strobe got=%0d exp=0", vq.size() + eq.size());
        end
        send_frame(8'h55, 1'b1, 1600, -1);
        idle(20);
        checks++;
        if (vq.size() != 1) begin
            failures++; $display("FAIL glitch_next_count got=%0d exp=1", vq.size());
        end else begin
            checks++;
            if (dq[0] !== 8'h55) begin failures++; $display("FAIL glitch_next_data got=%h exp=55", dq[0]); end
            checks++;
            if (vq[0] - t0 - 1 != 153) begin failures++; $display("FAIL glitch_next_edge got=%0d exp=153", vq[0] - t0 - 1); end
        end
    endtask

    task automatic test_framing_error();
        clear_q();
        send_frame(8'h12, 1'b0, 1600, -1);
        rs232rx = 1'b0;
        repeat (40 * 16) begin
            @(posedge clk);
            #1;
        end
        idle(20);
        checks++;
        if (eq.size() != 1) begin
            failures++; $display("FAIL ferr_count got=%0d exp=1", eq.size());
        end else begin
            checks++;
            if (eq[0] - t0 - 1 != 153) begin failures++; $display("FAIL ferr_edge got=%0d exp=153", eq[0] - t0 - 1); end
        end
        checks++;
        if (vq.size() != 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", vq.size()); end
        checks++;
        if (rxdata !== 8'h55) begin failures++; $display("FAIL ferr_hold got=%h exp=55", rxdata); end
        clear_q();
        send_frame(8'h34, 1'b1, 1600, -1);
        idle(20);
        checks++;
        if (vq.size() != 1 || eq.size() != 0) begin
            failures++; $display("FAIL ferr_next_count got=%0d/%0d exp=1/0", vq.size(), eq.size());
        end else begin
            checks++;
            if (dq[0] !== 8'h34) begin failures++; $display("FAIL ferr_next_data got=%h exp=34", dq[0]); end
        end
    endtask

    task automatic test_reset_midframe();
        clear_q();
        send_frame(8'hF8, 1'b1, 1600, 70);
        idle(20);
        checks++;
        if (vq.size() + eq.size() != 0) begin
            failures++; $display("FAIL midrst_strobe got=%0d exp=0", vq.size() + eq.size());
        end
        checks++;
        if (rxdata !== 8'h00) begin failures++; $display("FAIL midrst_rxdata got=%h exp=00", rxdata); end
        send_frame(8'hC3, 1'b1, 1600, -1);
        idle(20);
        checks++;
        if (vq.size() != 1) begin
            failures++; $display("FAIL midrst_next_count got=%0d exp=1", vq.size());
        end else begin
            checks++;
            if (dq[0] !== 8'hC3) begin failures++; $display("FAIL midrst_next_data got=%h exp=c3", dq[0]); end
        end
    endtask

    // Transmitter 4% slow / fast, alternating; every byte value once.
    task automatic test_baud_tolerance();
        logic [7:0] v;
        int errs;
        errs = 0;
        for (int k = 0; k < 256; k++) begin
            clear_q();
            v = 8'((k * 37 + 11) & 255);
            send_frame(v, 1'b1, (k % 2 == 1) ? 1664 : 1536, -1);
            idle(4);
            errs += eq.size();
            checks++;
            if (vq.size() != 1) begin
                failures++; $display("FAIL baud_count k=%0d got=%0d exp=1", k, vq.size());
            end else if (dq[0] !== v) begin
                failures++; $display("FAIL baud_data k=%0d got=%h exp=%h", k, dq[0], v);
            end
        end
        checks++;
        if (errs != 0) begin failures++; $display("FAIL baud_err got=%0d exp=0", errs); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_midframe();
        test_baud_tolerance();
        checks++;
        if (viol != 0) begin failures++; $display("FAIL strobe_rules got=%0d exp=0", viol); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
